// File: rtl/ecall_writeback_unit.sv
// ecall_writeback_unit
//   Services an ECALL for the core. The unit latches argument registers a0..a7,
//   presents them to the host with a valid/ready request, and waits for a result,
//   with an optional timeout. It then writes the result back to RET_REG through an
//   arbitrated register-file write port. The pipeline is stalled (busy) for the
//   whole transaction.
// Parameters
//   XLEN     register / result width
//   RET_REG  destination register for the result; 0 disables writeback
//   TIMEOUT  response wait limit in cycles; 0 waits forever
// Ports
//   clk, reset                     clock; synchronous active-low reset
//   ecall_valid / ecall_ready      ECALL handshake from execute (ready only in idle)
//   a0..a7                         argument taps from the register file
//   host_req_valid/_ready, host_args   request to host, {a7..a0}
//   host_resp_valid, host_resp_data    host result (honoured only while waiting)
//   wb_addr, wb_data, wb_en, wb_grant  register-file write port request/grant
//   busy, done, timed_out          stall, one-cycle completion pulse, sticky timeout
module ecall_writeback_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RET_REG = 10,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ecall_valid,
  output logic              ecall_ready,
  input  logic [XLEN-1:0]   a0,
  input  logic [XLEN-1:0]   a1,
  input  logic [XLEN-1:0]   a2,
  input  logic [XLEN-1:0]   a3,
  input  logic [XLEN-1:0]   a4,
  input  logic [XLEN-1:0]   a5,
  input  logic [XLEN-1:0]   a6,
  input  logic [XLEN-1:0]   a7,
  output logic              host_req_valid,
  input  logic              host_req_ready,
  output logic [8*XLEN-1:0] host_args,
  input  logic              host_resp_valid,
  input  logic [XLEN-1:0]   host_resp_data,
  output logic [4:0]        wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_en,
  input  logic              wb_grant,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [4:0] RetAddr = 5'(RET_REG);
  localparam bit HasWb = (RET_REG != 0);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StWb, StDone} state_e;

  state_e              state_q, state_d;
  logic [8*XLEN-1:0]   args_q, args_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timed_out_q, timed_out_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      args_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      args_q      <= args_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    args_d      = args_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      StIdle: begin
        if (ecall_valid) begin
          args_d      = {a7, a6, a5, a4, a3, a2, a1, a0};
          timed_out_d = 1'b0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (host_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (host_resp_valid) begin
          result_d = host_resp_data;
          state_d  = HasWb ? StWb : StDone;
        end else if ((TIMEOUT != 0) && (cnt_q == CntMax)) begin
          result_d    = '1;
          timed_out_d = 1'b1;
          state_d     = HasWb ? StWb : StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        if (wb_grant) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode only state and latched registers; no input-to-output paths.
  assign ecall_ready    = (state_q == StIdle);
  assign host_req_valid = (state_q == StReq);
  assign host_args      = args_q;
  assign wb_en          = (state_q == StWb);
  assign wb_addr        = wb_en ? RetAddr : 5'd0;
  assign wb_data        = wb_en ? result_q : '0;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign timed_out      = timed_out_q;

endmodule
